// File: rtl/wfid_done_collector.sv
// One-hot write-port mux with registered wfid/done outputs, plus a small FIFO
// that queues completed wfids for the wavefront tracker.
module wfid_done_collector #(
   parameter int unsigned NUM_PORTS  = 8,
   parameter int unsigned SEL_WIDTH  = 16,
   parameter int unsigned WFID_WIDTH = 6,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [SEL_WIDTH-1:0]            wr_port_select,
   input  logic [NUM_PORTS-1:0]            wfid_done,
   input  logic [NUM_PORTS*WFID_WIDTH-1:0] wfid,
   output logic [WFID_WIDTH-1:0]           muxed_wfid,
   output logic                            muxed_wfid_done,
   output logic                            sel_error,
   output logic                            done_valid,
   output logic [WFID_WIDTH-1:0]           done_wfid,
   input  logic                            done_ready,
   output logic [$clog2(DEPTH+1)-1:0]      done_count,
   output logic                            overflow,
   input  logic                            overflow_clr
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic                  any_low, multi_low, high_set;
   logic                  legal, idle, illegal;
   logic [WFID_WIDTH-1:0] sel_wfid;
   logic                  sel_done;

   // Decode and select in one pass; sel_wfid/sel_done hold the last set
   // in-range bit, which is only used when the select is legal.
   always_comb begin
      any_low   = 1'b0;
      multi_low = 1'b0;
      high_set  = 1'b0;
      sel_wfid  = '0;
      sel_done  = 1'b0;
      for (int unsigned i = 0; i < SEL_WIDTH; i++) begin
         if (wr_port_select[i]) begin
            if (i >= NUM_PORTS) begin
               high_set = 1'b1;
            end else begin
               if (any_low) multi_low = 1'b1;
               any_low  = 1'b1;
               sel_wfid = wfid[i*WFID_WIDTH +: WFID_WIDTH];
               sel_done = wfid_done[i];
            end
         end
      end
   end

   assign idle    = (wr_port_select == '0);
   assign legal   = any_low & ~multi_low & ~high_set;
   assign illegal = ~legal & ~idle;

   logic [WFID_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic                  push_req, pop, full, do_push, drop;

   assign push_req = legal & sel_done;
   assign full     = (count_q == CNT_W'(DEPTH));
   assign pop      = done_valid & done_ready;
   // A push into a full FIFO still lands if the head leaves on the same edge.
   assign do_push  = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         muxed_wfid      <= '0;
         muxed_wfid_done <= 1'b0;
         sel_error       <= 1'b0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         overflow        <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         muxed_wfid      <= legal ? sel_wfid : '0;
         muxed_wfid_done <= legal & sel_done;
         sel_error       <= illegal;
         if (do_push) begin
            mem_q[wr_ptr_q] <= sel_wfid;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(pop);
         if (drop) overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
      end
   end

   assign done_valid = (count_q != '0);
   assign done_wfid  = mem_q[rd_ptr_q];
   assign done_count = count_q;

endmodule

// File: tb/tb_wfid_done_collector.sv
// Directed bench for wfid_done_collector: select decode, registered mux,
// done FIFO ordering, full/overflow corners and asynchronous reset.
module tb_wfid_done_collector;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] wr_port_select = '0;
   logic [7:0]  wfid_done = '0;
   logic [47:0] wfid = '0;
   logic [5:0]  muxed_wfid;
   logic        muxed_wfid_done;
   logic        sel_error;
   logic        done_valid;
   logic [5:0]  done_wfid;
   logic        done_ready = 1'b0;
   logic [2:0]  done_count;
   logic        overflow;
   logic        overflow_clr = 1'b0;

   int errors = 0;
   int checks = 0;

   wfid_done_collector #(
      .NUM_PORTS(8), .SEL_WIDTH(16), .WFID_WIDTH(6), .DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .wr_port_select(wr_port_select), .wfid_done(wfid_done),
      .wfid(wfid), .muxed_wfid(muxed_wfid), .muxed_wfid_done(muxed_wfid_done),
      .sel_error(sel_error), .done_valid(done_valid), .done_wfid(done_wfid),
      .done_ready(done_ready), .done_count(done_count), .overflow(overflow),
      .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Background ids 40+i on every port, all done flags set, then port p overridden.
   task automatic drive_port(input int p, input logic [5:0] id, input logic d);
      for (int i = 0; i < 8; i++) wfid[i*6 +: 6] = 6'(40 + i);
      wfid[p*6 +: 6] = id;
      wfid_done      = 8'hff;
      wfid_done[p]   = d;
      wr_port_select = 16'(1) << p;
   endtask

   task automatic go_idle();
      wr_port_select = '0;
      wfid_done      = '0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      step();
      checks++; if (muxed_wfid !== 6'd0) begin errors++; $display("FAIL reset_muxed_wfid: got %0d expected 0", muxed_wfid); end
      checks++; if ({muxed_wfid_done, sel_error, done_valid, overflow} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {muxed_wfid_done, sel_error, done_valid, overflow}); end
      checks++; if (done_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", done_count); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_push();
      drive_port(2, 6'd21, 1'b1);
      step();
      go_idle();
      checks++; if (muxed_wfid !== 6'd21) begin errors++; $display("FAIL single_muxed_wfid: got %0d expected 21", muxed_wfid); end
      checks++; if (muxed_wfid_done !== 1'b1) begin errors++; $display("FAIL single_muxed_done: got %b expected 1", muxed_wfid_done); end
      checks++; if (done_valid !== 1'b1 || done_wfid !== 6'd21) begin errors++; $display("FAIL single_head: got valid=%b wfid=%0d expected valid=1 wfid=21", done_valid, done_wfid); end
      checks++; if (done_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", done_count); end
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
      checks++; if (done_valid !== 1'b0 || done_count !== 3'd0) begin errors++; $display("FAIL single_pop: got valid=%b count=%0d expected 0/0", done_valid, done_count); end
      checks++; if (muxed_wfid !== 6'd0 || muxed_wfid_done !== 1'b0) begin errors++; $display("FAIL single_idle_mux: got %0d/%b expected 0/0", muxed_wfid, muxed_wfid_done); end
      // Legal select with its own done flag low: mux follows, nothing queued.
      drive_port(5, 6'd33, 1'b0);
      step();
      go_idle();
      checks++; if (muxed_wfid !== 6'd33 || muxed_wfid_done !== 1'b0) begin errors++; $display("FAIL notdone_mux: got %0d/%b expected 33/0", muxed_wfid, muxed_wfid_done); end
      checks++; if (done_count !== 3'd0) begin errors++; $display("FAIL notdone_count: got %0d expected 0", done_count); end
   endtask

   task automatic test_illegal();
      wfid_done = 8'hff;
      wr_port_select = 16'h0003;
      step();
      checks++; if (sel_error !== 1'b1 || muxed_wfid_done !== 1'b0 || muxed_wfid !== 6'd0) begin errors++; $display("FAIL illegal_multi: got err=%b done=%b wfid=%0d expected 1/0/0", sel_error, muxed_wfid_done, muxed_wfid); end
      checks++; if (done_count !== 3'd0) begin errors++; $display("FAIL illegal_multi_push: got count %0d expected 0", done_count); end
      wr_port_select = 16'h0100;
      step();
      checks++; if (sel_error !== 1'b1 || muxed_wfid_done !== 1'b0) begin errors++; $display("FAIL illegal_high: got err=%b done=%b expected 1/0", sel_error, muxed_wfid_done); end
      checks++; if (done_count !== 3'd0) begin errors++; $display("FAIL illegal_high_push: got count %0d expected 0", done_count); end
      // Valid port bit plus an out-of-range bit is still illegal.
      wr_port_select = 16'h8001;
      step();
      checks++; if (sel_error !== 1'b1 || done_count !== 3'd0) begin errors++; $display("FAIL illegal_mixed: got err=%b count=%0d expected 1/0", sel_error, done_count); end
      wr_port_select = 16'h0000;
      step();
      checks++; if (sel_error !== 1'b0 || done_count !== 3'd0) begin errors++; $display("FAIL idle_select: got err=%b count=%0d expected 0/0", sel_error, done_count); end
      go_idle();
   endtask

   task automatic test_fill_overflow();
      done_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         drive_port(k % 8, 6'(k), 1'b1);
         step();
      end
      checks++; if (done_count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", done_count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b expected 1", overflow); end
      // Clear and a fresh drop on the same edge: the set wins.
      drive_port(6, 6'd6, 1'b1);
      overflow_clr = 1'b1;
      step();
      overflow_clr = 1'b0;
      go_idle();
      checks++; if (overflow !== 1'b1 || done_count !== 3'd4) begin errors++; $display("FAIL clr_vs_set: got ovf=%b count=%0d expected 1/4", overflow, done_count); end
      done_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         checks++; if (done_valid !== 1'b1 || done_wfid !== 6'(k)) begin errors++; $display("FAIL fill_drain_%0d: got valid=%b wfid=%0d expected 1/%0d", k, done_valid, done_wfid, k); end
         step();
      end
      done_ready = 1'b0;
      checks++; if (done_valid !== 1'b0 || done_count !== 3'd0) begin errors++; $display("FAIL fill_empty: got valid=%b count=%0d expected 0/0", done_valid, done_count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
      overflow_clr = 1'b1;
      step();
      overflow_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clr: got %b expected 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [5:0] exp_order [4];
      exp_order[0] = 6'd2; exp_order[1] = 6'd3; exp_order[2] = 6'd4; exp_order[3] = 6'd9;
      done_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         drive_port(k, 6'(k), 1'b1);
         step();
      end
      checks++; if (done_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", done_count); end
      drive_port(7, 6'd9, 1'b1);
      done_ready = 1'b1;
      #1;
      checks++; if (done_wfid !== 6'd1) begin errors++; $display("FAIL full_pop_head: got %0d expected 1", done_wfid); end
      step();
      go_idle();
      checks++; if (done_count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL full_push_pop: got count=%0d ovf=%b expected 4/0", done_count, overflow); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (done_wfid !== exp_order[k]) begin errors++; $display("FAIL full_drain_%0d: got %0d expected %0d", k, done_wfid, exp_order[k]); end
         step();
      end
      done_ready = 1'b0;
      checks++; if (done_count !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d expected 0", done_count); end
   endtask

   task automatic test_wrap();
      logic [5:0] q [$];
      int pushes = 0;
      int cycles = 0;
      logic pop_now, push_now;
      while ((pushes < 10 || q.size() != 0) && cycles < 200) begin
         done_ready = 1'($urandom_range(0, 1));
         pop_now    = done_ready && (q.size() != 0);
         push_now   = (pushes < 10) && (q.size() < 4 || pop_now);
         if (push_now) drive_port(pushes % 8, 6'(50 + pushes), 1'b1);
         else go_idle();
         if (pop_now) begin
            checks++; if (done_wfid !== q[0]) begin errors++; $display("FAIL wrap_order: got %0d expected %0d", done_wfid, q[0]); end
         end
         step();
         if (pop_now) void'(q.pop_front());
         if (push_now) begin
            q.push_back(6'(50 + pushes));
            pushes++;
         end
         checks++; if (done_count !== 3'(q.size())) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", done_count, q.size()); end
         cycles++;
      end
      go_idle();
      done_ready = 1'b0;
      checks++; if (cycles >= 200) begin errors++; $display("FAIL wrap_timeout: got %0d cycles expected under 200", cycles); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_reset_midstream();
      done_ready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         drive_port(k, 6'(20 + k), 1'b1);
         step();
      end
      drive_port(0, 6'd30, 1'b1);
      #2 rst = 1'b1;
      #1;
      checks++; if (done_valid !== 1'b0 || done_count !== 3'd0) begin errors++; $display("FAIL async_reset_fifo: got valid=%b count=%0d expected 0/0", done_valid, done_count); end
      checks++; if (muxed_wfid !== 6'd0 || muxed_wfid_done !== 1'b0) begin errors++; $display("FAIL async_reset_mux: got %0d/%b expected 0/0", muxed_wfid, muxed_wfid_done); end
      go_idle();
      @(negedge clk);
      rst = 1'b0;
      step();
      checks++; if (done_count !== 3'd0 || done_wfid !== 6'd0) begin errors++; $display("FAIL post_reset: got count=%0d head=%0d expected 0/0", done_count, done_wfid); end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_illegal();
      test_fill_overflow();
      test_full_push_pop();
      test_wrap();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
